// File: rtl/column_feeder_pkg.sv
// Shared defaults and FSM state encoding for the column feeder.
package column_feeder_pkg;

  localparam int unsigned SER_LANES_DEF    = 8;
  localparam int unsigned BITS_PER_COL_DEF = 256;
  localparam int unsigned NB_COLS_DEF      = 8;

  // Column mux outputs are active-low; all ones means every column is off.
  localparam logic [7:0] MUX_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SHIFT      = 3'd1,
    WAIT_BLANK = 3'd2,
    LATCH      = 3'd3,
    READY      = 3'd4,
    WAIT_ACK   = 3'd5
  } fsm_state_t;

endpackage

// File: rtl/column_feeder_serializer_phase.sv
// Two-phase shift-clock / data generator with framebuffer bit counter.
// While run is high: cycle 0 only presents address 0; every odd cycle
// captures fb_data (for the address shown the cycle before) with
// ser_clk low; every following even cycle raises ser_clk.
module serializer_phase
  import column_feeder_pkg::*;
#(
  parameter int unsigned SER_LANES    = SER_LANES_DEF,
  parameter int unsigned BITS_PER_COL = BITS_PER_COL_DEF
) (
  input  logic                            clk_33,
  input  logic                            nrst,
  input  logic                            run,
  input  logic [SER_LANES-1:0]            fb_data,
  output logic [$clog2(BITS_PER_COL)-1:0] bit_idx,
  output logic                            ser_clk,
  output logic [SER_LANES-1:0]            ser_data,
  output logic                            done
);

  localparam int unsigned CNT_W = $clog2(2 * BITS_PER_COL + 2);
  localparam int unsigned BIT_W = $clog2(BITS_PER_COL);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * BITS_PER_COL);

  logic [CNT_W-1:0] cnt;

  // Phase counter, read address and registered serial outputs.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      ser_clk  <= 1'b0;
      ser_data <= '0;
    end else if (!run) begin
      cnt     <= '0;
      bit_idx <= '0;
      ser_clk <= 1'b0;
    end else begin
      cnt <= cnt + CNT_W'(1);
      if (cnt[0]) begin
        ser_data <= fb_data;
        ser_clk  <= 1'b0;
        bit_idx  <= bit_idx + BIT_W'(1);
      end else if (cnt != '0) begin
        ser_clk <= 1'b1;
      end
    end
  end

  // Last SHIFT cycle: the final high phase is being registered now.
  assign done = run && (cnt == LAST_CNT);

endmodule

// File: rtl/column_feeder.sv
// Column feeder: shifts one column of framebuffer data into the LED
// drivers while the previous column is displayed, latches it only while
// the column mux is blanked, then hands the column to the mux.
module column_feeder
  import column_feeder_pkg::*;
#(
  parameter int unsigned SER_LANES    = SER_LANES_DEF,
  parameter int unsigned BITS_PER_COL = BITS_PER_COL_DEF,
  parameter int unsigned NB_COLS      = NB_COLS_DEF
) (
  input  logic                                                clk_33,
  input  logic                                                nrst,
  input  logic                                                enable,
  input  logic [7:0]                                          mux_out,
  output logic [$clog2(NB_COLS)+$clog2(BITS_PER_COL)-1:0]     fb_addr,
  input  logic [SER_LANES-1:0]                                fb_data,
  output logic                                                ser_clk,
  output logic [SER_LANES-1:0]                                ser_data,
  output logic                                                ser_lat,
  output logic                                                column_ready,
  output logic                                                busy
);

  localparam int unsigned COL_W = $clog2(NB_COLS);
  localparam int unsigned BIT_W = $clog2(BITS_PER_COL);

  fsm_state_t       state;
  fsm_state_t       state_nxt;
  logic [COL_W-1:0] col;
  logic [BIT_W-1:0] bit_idx;
  logic             shift_done;
  logic             blanked;
  logic             shifting;

  assign blanked  = (mux_out == MUX_BLANK);
  assign shifting = (state == SHIFT);

  serializer_phase #(
    .SER_LANES    (SER_LANES),
    .BITS_PER_COL (BITS_PER_COL)
  ) u_serializer_phase (
    .clk_33   (clk_33),
    .nrst     (nrst),
    .run      (shifting),
    .fb_data  (fb_data),
    .bit_idx  (bit_idx),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .done     (shift_done)
  );

  // Both fields are flops, so the address is a registered output.
  assign fb_addr = {col, bit_idx};

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (enable)     state_nxt = SHIFT;
      SHIFT:      if (shift_done) state_nxt = WAIT_BLANK;
      WAIT_BLANK: if (blanked)    state_nxt = LATCH;
      LATCH:                      state_nxt = READY;
      READY:                      state_nxt = WAIT_ACK;
      WAIT_ACK:   if (!blanked)   state_nxt = enable ? SHIFT : IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // State, column counter and strobes; strobes are decoded from the next
  // state so they line up with the state they belong to.
  always_ff @(posedge clk_33 or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      col          <= '0;
      ser_lat      <= 1'b0;
      column_ready <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      ser_lat      <= (state_nxt == LATCH);
      column_ready <= (state_nxt == READY);
      busy         <= (state_nxt != IDLE);
      if (state == WAIT_ACK && !blanked) begin
        col <= (col == COL_W'(NB_COLS - 1)) ? '0 : col + COL_W'(1);
      end
    end
  end

endmodule

// File: doc/column_feeder.md
COLUMN_FEEDER -- requirements
Module: column_feeder

Interface
REQ-001 Parameter SER_LANES, default 8, number of parallel LED-driver serial data lanes.
REQ-002 Parameter BITS_PER_COL, default 256, serial bits per lane per column (16 pixels x 16-bit grayscale).
REQ-003 Parameter NB_COLS, default 8, columns per rotation slot; fixed to match the 8-output column mux.
REQ-004 clk_33  in  1  33.33 MHz system clock.
REQ-005 nrst  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  high allows column loading; sampled only in IDLE.
REQ-007 mux_out  in  8  column mux outputs, active-low; 8'hFF = all columns blanked.
REQ-008 fb_addr  out  11  framebuffer read address {col[2:0], bit_idx[7:0]}.
REQ-009 fb_data  in  SER_LANES  framebuffer read data, valid one cycle after fb_addr.
REQ-010 ser_clk  out  1  LED-driver shift clock.
REQ-011 ser_data  out  SER_LANES  LED-driver serial data, one bit per lane.
REQ-012 ser_lat  out  1  LED-driver latch strobe.
REQ-013 column_ready  out  1  single-cycle pulse to the column mux: next column latched.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, SHIFT, WAIT_BLANK, LATCH, READY, WAIT_ACK.
REQ-016 IDLE -> SHIFT when enable=1; bit_idx cleared to 0 on entry.
REQ-017 SHIFT: fb_addr={col,bit_idx}; each bit occupies 2 cycles: phase 0 ser_clk=0 with ser_data=fb_data (registered); phase 1 ser_clk=1, data held.
REQ-018 ser_data changes only while ser_clk=0; one ser_clk rising edge per bit, BITS_PER_COL edges per column, bit_idx 0 shifted first.
REQ-019 The 1-cycle fb read latency is absorbed by issuing fb_addr one cycle ahead; SHIFT lasts exactly 2*BITS_PER_COL+1 cycles (513 default).
REQ-020 SHIFT -> WAIT_BLANK after the last ser_clk high phase; ser_clk returns to 0.
REQ-021 WAIT_BLANK -> LATCH when mux_out==8'hFF; loading overlaps the previous column's display, latching never does.
REQ-022 LATCH: ser_lat=1 for exactly 1 cycle, then READY.
REQ-023 READY: column_ready=1 for exactly 1 cycle, then WAIT_ACK.
REQ-024 WAIT_ACK -> SHIFT (or IDLE if enable=0) on the first cycle mux_out!=8'hFF; col increments on that transition.
REQ-025 col wraps 7 -> 0, keeping lockstep with the mux's own column counter.
REQ-026 column_ready is never asserted while mux_out!=8'hFF.
REQ-027 enable deassertion outside IDLE has no effect until WAIT_ACK exit; the in-flight column always completes.
REQ-028 If the mux is already blanked on WAIT_BLANK entry, LATCH follows in the next cycle (no added wait).

Reset
REQ-029 Asynchronous on nrst low: state=IDLE, col=0, bit_idx=0, fb_addr=0, ser_clk=0, ser_data=0, ser_lat=0, column_ready=0, busy=0.
REQ-030 Reset mid-SHIFT abandons the column; after release, loading restarts at col 0, bit 0; the mux and this block share nrst, so they resync.

Structure
REQ-031 Shared package holds NB_COLS, BITS_PER_COL, SER_LANES defaults and the FSM state enum.
REQ-032 Single module; one sub-module natural: serializer_phase (2-phase ser_clk/data generator with bit counter).
REQ-033 All outputs registered; no combinational path from mux_out to column_ready.

Verification
REQ-034 Reset release, enable=1, mux_out=FF: exactly 256 ser_clk rises, ser_lat at cycle 514, column_ready at 515, fb_addr 0..255.
REQ-035 Behavioral mux model (330-cycle DISP): 16 columns complete, col sequence 0..7,0..7, no column_ready while mux_out!=FF.
REQ-036 fb_data = bit_idx[7:0] parity pattern per lane: captured shift data matches framebuffer bit-for-bit, col 3 addresses 0x300-0x3FF.
REQ-037 mux_out held 8'hFE for 1000 cycles after SHIFT ends: FSM stays WAIT_BLANK, ser_lat=0 until mux_out=FF.
REQ-038 nrst pulse at bit 100 of col 5: all outputs zero immediately, next load starts col 0 bit 0.
REQ-039 enable dropped during SHIFT of col 2: col 2 completes through WAIT_ACK, then IDLE, busy=0, col=3.
